ext_adc_spi_responder: RTL

//  Converter-side end of the AdcDoConvert/AdcConvComplete/AdcValue handshake used by ExtADC-style apps.

---
 rtl/ext_adc_spi_responder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ext_adc_spi_responder.sv
// Converter-side responder: one request runs an external serial ADC read and returns the word with a level flag.
// Latency: Complete rises 1+ConvCycles+2*DataWidth*(ClkDiv+1) edges after the start edge. Backpressure: four-phase level handshake.
// EXTADC_RESP_OVERSAMPLE_EN: four back-to-back conversions per request, averaged result.
module ext_adc_spi_responder #(
  parameter int DataWidth  = 16,
  parameter int ConvCycles = 4,
  parameter int DivWidth   = 8
) (
  input  logic                 Clk_i,
  input  logic                 Reset_i,
  input  logic                 AdcDoConvert_i,
  output logic                 AdcConvComplete_o,
  output logic [DataWidth-1:0] AdcValue_o,
  input  logic [DivWidth-1:0]  ClkDiv_i,
  output logic                 SpiCS_n_o,
  output logic                 SpiSCK_o,
  input  logic                 SpiMISO_i
);

  localparam int WaitW = $clog2(ConvCycles + 1);
  localparam int BitW  = (DataWidth > 1) ? $clog2(DataWidth) : 1;

  typedef enum logic [2:0] {Idle, CsWait, Shift, Done, Gap} state_t;

  state_t               state;
  logic                 complete;
  logic [DataWidth-1:0] value;
  logic                 csN;
  logic                 sck;
  logic [DivWidth-1:0]  div;
  logic [DivWidth-1:0]  divCnt;
  logic [WaitW-1:0]     waitCnt;
  logic [BitW-1:0]      bitCnt;
  logic [DataWidth-1:0] shiftReg;
`ifdef EXTADC_RESP_OVERSAMPLE_EN
  logic [1:0]           seqCnt;
  logic [DataWidth+1:0] acc;
`endif

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state    <= Idle;
      complete <= 1'b0;
      value    <= '0;
      csN      <= 1'b1;
      sck      <= 1'b0;
      div      <= '0;
      divCnt   <= '0;
      waitCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
`ifdef EXTADC_RESP_OVERSAMPLE_EN
      seqCnt   <= '0;
      acc      <= '0;
`endif
    end else begin
      case (state)
        Idle: begin
          if (AdcDoConvert_i) begin
            div     <= ClkDiv_i;
            csN     <= 1'b0;
            waitCnt <= '0;
            state   <= CsWait;
`ifdef EXTADC_RESP_OVERSAMPLE_EN
            seqCnt  <= '0;
            acc     <= '0;
`endif
          end
        end

        CsWait: begin
          if (!AdcDoConvert_i) begin
            csN   <= 1'b1;
            sck   <= 1'b0;
            state <= Idle;
          end else if (waitCnt == WaitW'(ConvCycles)) begin
            divCnt <= '0;
            bitCnt <= '0;
            state  <= Shift;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end

        Shift: begin
          if (!AdcDoConvert_i) begin
            csN   <= 1'b1;
            sck   <= 1'b0;
            state <= Idle;
          end else if (divCnt != div) begin
            divCnt <= divCnt + 1'b1;
          end else begin
            divCnt <= '0;
            if (!sck) begin
              // MISO is sampled on the edge that raises SCK
              sck      <= 1'b1;
              shiftReg <= {shiftReg[DataWidth-2:0], SpiMISO_i};
            end else if (bitCnt != BitW'(DataWidth - 1)) begin
              sck    <= 1'b0;
              bitCnt <= bitCnt + 1'b1;
            end else begin
              sck <= 1'b0;
              csN <= 1'b1;
`ifdef EXTADC_RESP_OVERSAMPLE_EN
              if (seqCnt == 2'd3) begin
                value    <= DataWidth'((acc + {2'b00, shiftReg}) >> 2);
                complete <= 1'b1;
                state    <= Done;
              end else begin
                acc    <= acc + {2'b00, shiftReg};
                seqCnt <= seqCnt + 1'b1;
                state  <= Gap;
              end
`else
              value    <= shiftReg;
              complete <= 1'b1;
              state    <= Done;
`endif
            end
          end
        end

        Gap: begin
          if (!AdcDoConvert_i) begin
            state <= Idle;
          end else begin
            csN     <= 1'b0;
            waitCnt <= '0;
            state   <= CsWait;
          end
        end

        Done: begin
          if (!AdcDoConvert_i) begin
            complete <= 1'b0;
            state    <= Idle;
          end
        end

        default: begin
          csN   <= 1'b1;
          sck   <= 1'b0;
          state <= Idle;
        end
      endcase
    end
  end

  assign AdcConvComplete_o = complete;
  assign AdcValue_o        = value;
  assign SpiCS_n_o         = csN;
  assign SpiSCK_o          = sck;

endmodule
